clut_loader: RTL and testbench

//  Write-side master for the colour lookup table system port. Accepts a load command
//  (start index, entry count) plus a valid/ready stream of colour words. Writes each word
//  to consecutive CLUT entries on clk_sys, for palette upload or replacement.

---
 rtl/clut_loader.sv | 182 ++++++++++++++++++
 tb/tb_clut_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clut_loader.sv
// CLUT write-side loader: takes a (start index, count) command and streams colour words
// into consecutive CLUT entries. Define CLUT_VERIFY_EN to add a read-back checksum pass.
module clut_loader #(
  parameter int ADDRW = 4,
  parameter int DATAW = 12
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic [ADDRW:0]   cmd_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DATAW-1:0] s_data,
  output logic             clut_we,
  output logic [ADDRW-1:0] clut_addr,
  output logic [DATAW-1:0] clut_din,
  input  logic [DATAW-1:0] clut_dout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [ADDRW:0] DEPTH = (ADDRW+1)'(2**ADDRW);
  localparam logic [ADDRW:0] ONE   = (ADDRW+1)'(1);

`ifdef CLUT_VERIFY_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
`endif

  state_t           r_state;
  logic             r_cmd_ready;
  logic             r_s_ready;
  logic             r_we;
  logic             r_done;
  logic [ADDRW-1:0] r_addr;
  logic [DATAW-1:0] r_din;
  logic [ADDRW-1:0] r_idx;
  logic [ADDRW:0]   r_rem;

`ifdef CLUT_VERIFY_EN
  logic [ADDRW-1:0] r_start;
  logic [ADDRW:0]   r_len;
  logic [DATAW-1:0] r_wsum;
  logic [DATAW-1:0] r_rsum;
  logic             r_rd_a;   // a read address is on clut_addr this cycle
  logic             r_rd_v;   // read data for the previous address is on clut_dout
  logic             r_err;
`else
  logic w_unused_dout;
  assign w_unused_dout = ^clut_dout;
`endif

  logic [ADDRW:0] w_len;
  logic           w_cmd_fire;
  logic           w_s_fire;

  assign w_len      = (cmd_len > DEPTH) ? DEPTH : cmd_len;
  assign w_cmd_fire = cmd_valid && r_cmd_ready;
  assign w_s_fire   = s_valid && r_s_ready;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_s_ready   <= 1'b0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_idx       <= '0;
      r_rem       <= '0;
`ifdef CLUT_VERIFY_EN
      r_start     <= '0;
      r_len       <= '0;
      r_wsum      <= '0;
      r_rsum      <= '0;
      r_rd_a      <= 1'b0;
      r_rd_v      <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_cmd_ready <= 1'b0;
            r_idx       <= cmd_addr;
            r_rem       <= w_len;
`ifdef CLUT_VERIFY_EN
            r_start     <= cmd_addr;
            r_len       <= w_len;
            r_wsum      <= '0;
            r_rsum      <= '0;
            r_err       <= 1'b0;
`endif
            if (w_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_WRITE;
              r_s_ready <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (w_s_fire) begin
            r_we      <= 1'b1;
            r_addr    <= r_idx;
            r_din     <= s_data;
            r_idx     <= r_idx + ADDRW'(1);
            r_rem     <= r_rem - ONE;
            r_s_ready <= (r_rem > ONE);
`ifdef CLUT_VERIFY_EN
            r_wsum    <= r_wsum + s_data;
`endif
          end else if (r_rem == '0) begin
            // The final write cycle has just finished on the CLUT port.
`ifdef CLUT_VERIFY_EN
            r_state <= S_VERIFY;
            r_addr  <= r_start;
            r_rd_a  <= 1'b1;
            r_rem   <= r_len - ONE;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef CLUT_VERIFY_EN
        S_VERIFY: begin
          r_rd_v <= r_rd_a;
          if (r_rd_a) begin
            if (r_rem != '0) begin
              r_addr <= r_addr + ADDRW'(1);
              r_rem  <= r_rem - ONE;
            end else begin
              r_rd_a <= 1'b0;
            end
          end
          if (r_rd_v) r_rsum <= r_rsum + clut_dout;
          // Last sample arrives with no address outstanding; fold it into the compare.
          if (r_rd_v && !r_rd_a) begin
            r_err   <= (r_wsum != DATAW'(r_rsum + clut_dout));
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_s_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = ~r_cmd_ready;
  assign s_ready   = r_s_ready;
  assign clut_we   = r_we;
  assign clut_addr = r_addr;
  assign clut_din  = r_din;
  assign done      = r_done;
`ifdef CLUT_VERIFY_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_clut_loader.sv
// Randomized bench for clut_loader: a behavioural CLUT, an expected-write list and an
// expected memory image derived from the load commands.
module tb_clut_loader;

`ifdef CLUT_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_addr;
  logic [4:0]  cmd_len;
  logic        s_valid, s_ready;
  logic [11:0] s_data;
  logic        clut_we;
  logic [3:0]  clut_addr;
  logic [11:0] clut_din, clut_dout;
  logic        busy, done, err;

  always #5 clk_sys = ~clk_sys;

  clut_loader #(.ADDRW(4), .DATAW(12)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .clut_we(clut_we), .clut_addr(clut_addr), .clut_din(clut_din), .clut_dout(clut_dout),
    .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // CLUT model: synchronous write, 1-cycle read, read data held during writes.
  logic [11:0] mem [16];
  logic [11:0] exp_mem [16];
  bit          corrupt_en = 1'b0;
  always @(posedge clk_sys) begin
    if (clut_we) mem[clut_addr] <= (corrupt_en && clut_addr == 4'd5) ? ~clut_din : clut_din;
    else         clut_dout <= mem[clut_addr];
  end

  // Port monitor, sampled on the falling edge.
  logic [15:0] wr_q [$];
  int done_cnt = 0;
  int last_we_cyc = 0;
  always @(negedge clk_sys) begin
    if (clut_we) begin
      wr_q.push_back({clut_addr, clut_din});
      last_we_cyc <= cyc;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_load(input logic [3:0] a, input logic [4:0] n, input int gap_pct,
                         input bit pester, input bit corrupt, input bit fixed,
                         input int abort_after);
    int L, n_wr, idx, hs, seen_cyc, exp_done, wr_base, done_base, mism;
    bit fire_pend, got_hs, seen_done, aborted;
    logic err_at_done, exp_err;
    logic [11:0] words [$];
    logic [15:0] exp_q [$];
    logic [3:0]  ia;

    L = (n > 5'd16) ? 16 : int'(n);
    n_wr = (abort_after > 0) ? abort_after : L;
    exp_err = 1'b0;
    for (int i = 0; i < L; i++) begin
      logic [11:0] w;
      w = fixed ? 12'(32'h111 * (i + 1)) : 12'($urandom);
      words.push_back(w);
      ia = a + 4'(i);
      if (i < n_wr) begin
        exp_q.push_back({ia, w});
        exp_mem[ia] = (corrupt && ia == 4'd5) ? ~w : w;
        if (corrupt && ia == 4'd5) exp_err = VERIFY;
      end
    end
    corrupt_en = corrupt;

    @(negedge clk_sys); #1;
    wr_base = wr_q.size();
    done_base = done_cnt;
    check("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = n; s_valid = 1'b0;
    fire_pend = 0; got_hs = 0; seen_done = 0; aborted = 0; idx = 0;
    hs = 0; seen_cyc = 0; err_at_done = 1'b0;

    for (int t = 0; t < 400 && !seen_done && !aborted; t++) begin
      @(negedge clk_sys); #1;
      if (!got_hs) begin
        got_hs = 1; hs = cyc;
        check("err_clear", err, 0);
        cmd_valid = pester; cmd_addr = ~a; cmd_len = 5'd3;
      end
      if (fire_pend) begin
        idx++;
        if (idx == L) check("s_ready_drop", s_ready, 0);
      end
      if (abort_after > 0 && (wr_q.size() - wr_base) == abort_after) begin
        @(posedge clk_sys); #2;
        rst_sys_n = 1'b0; s_valid = 1'b0; cmd_valid = 1'b0;
        #1;
        check("rst_outputs", {cmd_ready, busy, clut_we, s_ready, done}, 5'b10000);
        @(negedge clk_sys); rst_sys_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        #1;
        check("abort_no_done", done_cnt - done_base, 0);
        check("abort_idle", {cmd_ready, busy}, 2'b10);
        aborted = 1;
      end else if (done) begin
        seen_done = 1; seen_cyc = cyc; err_at_done = err;
        s_valid = 1'b0; cmd_valid = 1'b0;
      end else begin
        s_valid = ($urandom_range(99) >= gap_pct);
        s_data = (idx < L) ? words[idx] : 12'($urandom);
        fire_pend = s_valid && s_ready;
      end
    end
    s_valid = 1'b0; cmd_valid = 1'b0;

    if (!aborted) begin
      check("done_seen", seen_done, 1);
      if (seen_done) begin
        exp_done = (L == 0) ? hs : last_we_cyc + 1 + (VERIFY ? L + 1 : 0);
        check("done_time", seen_cyc, exp_done);
        if (gap_pct == 0)
          check("done_latency", seen_cyc - hs, (L == 0) ? 0 : L + 1 + (VERIFY ? L + 1 : 0));
        check("err_at_done", err_at_done, exp_err);
        @(negedge clk_sys); #1;
        check("busy_fall", {busy, cmd_ready, done}, 3'b010);
        check("err_hold", err, exp_err);
        check("done_once", done_cnt - done_base, 1);
      end else begin
        rst_sys_n = 1'b0; #3 rst_sys_n = 1'b1;
      end
    end

    check("wr_count", wr_q.size() - wr_base, exp_q.size());
    if (wr_q.size() - wr_base == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) check("wr_entry", wr_q[wr_base + i], exp_q[i]);
    mism = 0;
    for (int j = 0; j < 16; j++) if (mem[j] !== exp_mem[j]) mism++;
    check("clut_mem", mism, 0);
    corrupt_en = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < 16; j++) begin
      mem[j] = '0;
      exp_mem[j] = '0;
    end
    clut_dout = '0;
    rst_sys_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk_sys);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_we", clut_we, 0);
    check("rst_done_err", {done, err}, 2'b00);
    check("rst_addr_din", {clut_addr, clut_din}, 16'h0000);
    rst_sys_n = 1'b1;

    do_load(4'd0,  5'd8,  0, 1'b0, 1'b0, 1'b0, 3);   // reset after 3 of 8 words
    do_load(4'd2,  5'd4,  0, 1'b0, 1'b0, 1'b1, 0);   // 0x111..0x444 at idx 2..5
    do_load(4'd14, 5'd4,  0, 1'b0, 1'b0, 1'b0, 0);   // wraps 14,15,0,1
    do_load(4'd9,  5'd0,  0, 1'b0, 1'b0, 1'b0, 0);   // no-op
    do_load(4'd7,  5'd20, 0, 1'b0, 1'b0, 1'b0, 0);   // clamps to 16
    do_load(4'd11, 5'd6, 50, 1'b1, 1'b0, 1'b0, 0);   // stalls with cmd_valid held
    do_load(4'd3,  5'd6,  0, 1'b0, 1'b1, 1'b0, 0);   // idx 5 corrupted by the CLUT
    do_load(4'd0,  5'd16, 0, 1'b0, 1'b0, 1'b0, 0);   // clean full load
    for (int k = 0; k < 6; k++)
      do_load(4'($urandom), 5'($urandom_range(0, 20)), int'($urandom_range(0, 60)),
              1'($urandom_range(0, 1)), 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
